// File: rtl/video_timing_pkg.sv
// Shared types, constants and helpers for the video timing generator/formatter.
package video_timing_pkg;

    localparam int unsigned CNT_W = 12;
    localparam int unsigned RGB_W = 24;

    typedef enum logic [1:0] {
        MODE_STREAM = 2'd0,
        MODE_BARS   = 2'd1,
        MODE_SOLID  = 2'd2,
        MODE_RSVD   = 2'd3
    } vid_mode_e;

    // Timing decode for one counter position, handed from the counter to the formatter
    typedef struct packed {
        logic             frame_start;
        logic             line_start;
        logic             hs;
        logic             vs;
        logic             de;
        logic             req;
        logic [CNT_W-1:0] x_req;
        logic [CNT_W-1:0] y_req;
        logic [CNT_W-1:0] x_de;
    } timing_t;

    localparam logic [RGB_W-1:0] BAR_0 = 24'hFFFFFF;
    localparam logic [RGB_W-1:0] BAR_1 = 24'hFFFF00;
    localparam logic [RGB_W-1:0] BAR_2 = 24'h00FFFF;
    localparam logic [RGB_W-1:0] BAR_3 = 24'h00FF00;
    localparam logic [RGB_W-1:0] BAR_4 = 24'hFF00FF;
    localparam logic [RGB_W-1:0] BAR_5 = 24'hFF0000;
    localparam logic [RGB_W-1:0] BAR_6 = 24'h0000FF;
    localparam logic [RGB_W-1:0] BAR_7 = 24'h000000;

    // Colour of bar idx, left to right
    function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
        logic [RGB_W-1:0] c;
        case (idx)
            3'd0:    c = BAR_0;
            3'd1:    c = BAR_1;
            3'd2:    c = BAR_2;
            3'd3:    c = BAR_3;
            3'd4:    c = BAR_4;
            3'd5:    c = BAR_5;
            3'd6:    c = BAR_6;
            default: c = BAR_7;
        endcase
        return c;
    endfunction

    // RGB565 to RGB888 by replicating the top bits into the new LSBs
    function automatic logic [RGB_W-1:0] expand565(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    // Line or frame length from its four regions
    function automatic int unsigned total_count(input int unsigned sync_w,
                                                input int unsigned bp_w,
                                                input int unsigned active_w,
                                                input int unsigned fp_w);
        return sync_w + bp_w + active_w + fp_w;
    endfunction

endpackage

// File: rtl/video_sync_counter.sv
// H/V position counters with region decode and the look-ahead request window.
module video_sync_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned REQ_LEAD = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    output timing_t timing_c
);

    localparam int unsigned H_TOTAL = total_count(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int unsigned V_TOTAL = total_count(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int unsigned LEAD_W  = CNT_W + 1;

    localparam logic [CNT_W-1:0]  H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]  V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0]  H_SYNC_END = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0]  V_SYNC_END = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0]  H_ACT_BEG  = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0]  H_ACT_END  = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0]  V_ACT_BEG  = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0]  V_ACT_END  = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [LEAD_W-1:0] LEAD       = LEAD_W'(REQ_LEAD);

    if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_total_chk
        $error("video_sync_counter: H_TOTAL and V_TOTAL must not exceed 4095");
    end
    if (REQ_LEAD == 0 || REQ_LEAD > H_SYNC + H_BP) begin : g_lead_chk
        $error("video_sync_counter: REQ_LEAD must be in 1..H_SYNC+H_BP");
    end

    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;
    logic [LEAD_W-1:0] h_lead_c;
    logic              h_act_c;
    logic              v_act_c;
    logic              lead_act_c;

    // Position counters; v advances when the line wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    // Decode of the current position and of the position REQ_LEAD cycles ahead.
    // The ahead position never needs to wrap: past the line end it lands in
    // the next line's sync/back porch, which is never active.
    always_comb begin
        h_act_c    = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
        v_act_c    = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
        h_lead_c   = {1'b0, h_cnt} + LEAD;
        lead_act_c = (h_lead_c >= {1'b0, H_ACT_BEG}) && (h_lead_c < {1'b0, H_ACT_END});

        timing_c             = '0;
        timing_c.frame_start = (h_cnt == '0) && (v_cnt == '0);
        timing_c.line_start  = (h_cnt == '0);
        timing_c.hs          = (h_cnt < H_SYNC_END) ? HS_POL : ~HS_POL;
        timing_c.vs          = (v_cnt < V_SYNC_END) ? VS_POL : ~VS_POL;
        timing_c.de          = h_act_c && v_act_c;
        timing_c.req         = lead_act_c && v_act_c;
        if (timing_c.req) begin
            timing_c.x_req = CNT_W'(h_lead_c - {1'b0, H_ACT_BEG});
            timing_c.y_req = v_cnt - V_ACT_BEG;
        end
        if (timing_c.de) begin
            timing_c.x_de = h_cnt - H_ACT_BEG;
        end
    end

endmodule

// File: rtl/video_timing_fmt.sv
// Video timing generator and pixel formatter feeding the HDMI transmitter.
module video_timing_fmt
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned REQ_LEAD = 1,
    parameter int unsigned IN_W     = 16
) (
    input  logic             pixel_clk,
    input  logic             sys_rst_n,
    input  logic [1:0]       mode,
    input  logic [RGB_W-1:0] solid_rgb,
    input  logic [IN_W-1:0]  data_in,
    output logic             data_req,
    output logic [CNT_W-1:0] pixel_xpos,
    output logic [CNT_W-1:0] pixel_ypos,
    output logic             video_hs,
    output logic             video_vs,
    output logic             video_de,
    output logic [RGB_W-1:0] video_rgb,
    output logic             frame_start,
    output logic             line_start
);

    localparam int unsigned BAR_W = H_ACTIVE / 8;

    if (IN_W != 16 && IN_W != 24) begin : g_inw_chk
        $error("video_timing_fmt: IN_W must be 16 or 24");
    end

    timing_t          tm_c;
    vid_mode_e        mode_q;
    logic             stream_c;
    logic             req_c;
    logic [2:0]       bar_idx_c;
    logic [RGB_W-1:0] in_rgb_c;
    logic [RGB_W-1:0] rgb_c;

    video_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL),
        .REQ_LEAD (REQ_LEAD)
    ) u_sync (
        .clk      (pixel_clk),
        .rst_n    (sys_rst_n),
        .timing_c (tm_c)
    );

    // Upstream pixel widened to 888
    if (IN_W == 16) begin : g_in565
        assign in_rgb_c = expand565(data_in[15:0]);
    end else begin : g_in888
        assign in_rgb_c = data_in[RGB_W-1:0];
    end

    // Mode is captured once per frame so a frame never mixes sources
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q <= MODE_STREAM;
        end else if (tm_c.frame_start) begin
            mode_q <= vid_mode_e'(mode);
        end
    end

    // Pixel source select; the last bar absorbs any remainder of H_ACTIVE/8
    always_comb begin
        bar_idx_c = '0;
        rgb_c     = '0;
        stream_c  = (mode_q == MODE_STREAM) || (mode_q == MODE_RSVD);
        req_c     = tm_c.req && stream_c;
        for (int unsigned b = 1; b < 8; b++) begin
            if (tm_c.x_de >= CNT_W'(b * BAR_W)) begin
                bar_idx_c = 3'(b);
            end
        end
        if (tm_c.de) begin
            case (mode_q)
                MODE_BARS:  rgb_c = bar_colour(bar_idx_c);
                MODE_SOLID: rgb_c = solid_rgb;
                default:    rgb_c = in_rgb_c;
            endcase
        end
    end

    // Output pipeline register
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            video_hs    <= ~HS_POL;
            video_vs    <= ~VS_POL;
            video_de    <= 1'b0;
            video_rgb   <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            data_req    <= 1'b0;
            pixel_xpos  <= '0;
            pixel_ypos  <= '0;
        end else begin
            video_hs    <= tm_c.hs;
            video_vs    <= tm_c.vs;
            video_de    <= tm_c.de;
            video_rgb   <= rgb_c;
            frame_start <= tm_c.frame_start;
            line_start  <= tm_c.line_start;
            data_req    <= req_c;
            pixel_xpos  <= req_c ? tm_c.x_req : '0;
            pixel_ypos  <= req_c ? tm_c.y_req : '0;
        end
    end

endmodule

// File: tb/tb_video_timing_fmt.sv
// Self-checking bench for video_timing_fmt on a small 15x8 raster.
module tb_video_timing_fmt;

    localparam int P_HA = 8, P_HF = 2, P_HSY = 2, P_HBP = 3;
    localparam int P_VA = 4, P_VF = 1, P_VSY = 1, P_VBP = 2;
    localparam int P_LEAD = 3;
    localparam int P_INW  = 16;
    localparam bit P_HPOL = 1'b0;
    localparam bit P_VPOL = 1'b0;
    localparam int HT     = P_HSY + P_HBP + P_HA + P_HF;
    localparam int VT     = P_VSY + P_VBP + P_VA + P_VF;
    localparam int FT     = HT * VT;
    localparam int HSTART = P_HSY + P_HBP;
    localparam int VSTART = P_VSY + P_VBP;
    localparam int NPLAN  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        mode;
    logic [23:0]       solid_rgb;
    logic [P_INW-1:0]  data_in;
    logic              data_req;
    logic [11:0]       pixel_xpos;
    logic [11:0]       pixel_ypos;
    logic              video_hs;
    logic              video_vs;
    logic              video_de;
    logic [23:0]       video_rgb;
    logic              frame_start;
    logic              line_start;

    always #5 clk = ~clk;

    video_timing_fmt #(
        .H_ACTIVE (P_HA), .H_FP (P_HF), .H_SYNC (P_HSY), .H_BP (P_HBP),
        .V_ACTIVE (P_VA), .V_FP (P_VF), .V_SYNC (P_VSY), .V_BP (P_VBP),
        .HS_POL (P_HPOL), .VS_POL (P_VPOL), .REQ_LEAD (P_LEAD), .IN_W (P_INW)
    ) dut (
        .pixel_clk   (clk),
        .sys_rst_n   (rst_n),
        .mode        (mode),
        .solid_rgb   (solid_rgb),
        .data_in     (data_in),
        .data_req    (data_req),
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .video_hs    (video_hs),
        .video_vs    (video_vs),
        .video_de    (video_de),
        .video_rgb   (video_rgb),
        .frame_start (frame_start),
        .line_start  (line_start)
    );

    typedef struct {
        logic [15:0] din;
        logic [23:0] exp;
    } vec_t;

    vec_t        tbl [8];
    logic [23:0] bar_tab [8];
    logic [1:0]  plan [NPLAN];
    logic [23:0] solid_plan [NPLAN];
    logic [23:0] cap [8];
    logic [15:0] up_d [P_LEAD];
    int unsigned salt;
    int          errors = 0;
    int          checks = 0;
    int          k;
    int          last_fs, de_cnt, hs_cnt;
    bit          hs_seen, prev_req, prev_de;
    int          lead_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, k, act, exp);
        end
    endtask

    function automatic bit act_at(input int p);
        int h = p % HT;
        int v = (p / HT) % VT;
        return (h >= HSTART) && (h < HSTART + P_HA) && (v >= VSTART) && (v < VSTART + P_VA);
    endfunction

    function automatic bit is_stream(input logic [1:0] m);
        return (m == 2'd0) || (m == 2'd3);
    endfunction

    // Upstream pixel content; frame 1 serves the format-conversion table
    function automatic logic [15:0] pix(input int f, input int x, input int y);
        if (f == 1) return tbl[x % 8].din;
        return 16'((x * 40503) ^ (y * 2654) ^ (f * 7919) ^ salt);
    endfunction

    function automatic logic [23:0] exp565(input logic [15:0] d);
        int r = int'(d[15:11]);
        int g = int'(d[10:5]);
        int b = int'(d[4:0]);
        return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
    endfunction

    function automatic int bar_of(input int x);
        int i = x / (P_HA / 8);
        return (i > 7) ? 7 : i;
    endfunction

    task automatic check_reset(input string name);
        chk(name, 64'({video_hs, video_vs, video_de, data_req, frame_start, line_start,
                       video_rgb, pixel_xpos, pixel_ypos}),
                  64'({!P_HPOL, !P_VPOL, 4'b0000, 24'd0, 12'd0, 12'd0}));
    endtask

    // Compare outputs after k edges against the raster model
    task automatic check_cycle();
        int p  = k - 1;
        int q  = k + P_LEAD - 1;
        int fp = p / FT;
        int fq = q / FT;
        int hp = p % HT;
        int vp = (p / HT) % VT;
        int hq = q % HT;
        int vq = (q / HT) % VT;
        bit de_e  = act_at(p);
        bit req_e = act_at(q) && is_stream(plan[fq]);
        bit hs_e  = (hp < P_HSY) ? P_HPOL : !P_HPOL;
        bit vs_e  = (vp < P_VSY) ? P_VPOL : !P_VPOL;
        logic [23:0] rgb_e = '0;
        if (de_e) begin
            case (plan[fp])
                2'd1:    rgb_e = bar_tab[bar_of(hp - HSTART)];
                2'd2:    rgb_e = solid_plan[fp];
                default: rgb_e = exp565(pix(fp, hp - HSTART, vp - VSTART));
            endcase
        end
        chk("timing", 64'({video_hs, video_vs, video_de, frame_start, line_start}),
                      64'({hs_e, vs_e, de_e, (hp == 0 && vp == 0), (hp == 0)}));
        chk("request", 64'({data_req, pixel_xpos, pixel_ypos}),
                       64'({req_e, req_e ? 12'(hq - HSTART) : 12'd0, req_e ? 12'(vq - VSTART) : 12'd0}));
        chk("rgb", 64'(video_rgb), 64'(rgb_e));

        if (frame_start) begin
            if (last_fs >= 0) begin
                chk("frame_period", 64'(k - last_fs), 64'(FT));
                chk("de_per_frame", 64'(de_cnt), 64'(P_HA * P_VA));
            end
            last_fs = k;
            de_cnt  = 0;
        end
        if (video_de) de_cnt++;
        if (line_start) begin
            if (hs_seen) chk("hs_width", 64'(hs_cnt), 64'(P_HSY));
            hs_cnt  = 0;
            hs_seen = 1'b1;
        end
        if (video_hs == P_HPOL) hs_cnt++;
        if (data_req && !prev_req) lead_q.push_back(k + P_LEAD);
        if (lead_q.size() > 0 && lead_q[0] == k) begin
            void'(lead_q.pop_front());
            chk("req_to_de", 64'({video_de, prev_de}), 64'(2'b10));
        end
        prev_req = data_req;
        prev_de  = video_de;
        if (fp == 1 && vp == VSTART && de_e) cap[hp - HSTART] = video_rgb;
    endtask

    // Release reset and run ncyc edges; optionally re-assert reset at edge rst_at
    task automatic run(input int ncyc, input int rst_at);
        last_fs  = -1;
        de_cnt   = 0;
        hs_cnt   = 0;
        hs_seen  = 1'b0;
        prev_req = 1'b0;
        prev_de  = 1'b0;
        lead_q.delete();
        for (int i = 0; i < P_LEAD; i++) up_d[i] = '0;
        data_in   = '0;
        mode      = plan[0];
        solid_rgb = solid_plan[0];
        k = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset("release");
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            k++;
            #1;
            check_cycle();
            for (int i = P_LEAD - 1; i > 0; i--) up_d[i] = up_d[i-1];
            up_d[0] = data_req ? pix((k + P_LEAD - 1) / FT, int'(pixel_xpos), int'(pixel_ypos))
                               : 16'($urandom);
            data_in = up_d[P_LEAD-1];
            if (k % FT == 2 * HT + 5) mode = plan[k / FT + 1];
            if (k % FT == 7 * HT + 5) solid_rgb = solid_plan[k / FT + 1];
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_reset("async_reset");
                return;
            end
        end
    endtask

    initial begin
        salt = $urandom;
        tbl[0] = '{16'hF800, 24'hFF0000};
        tbl[1] = '{16'h0841, 24'h080808};
        tbl[2] = '{16'hFFFF, 24'hFFFFFF};
        tbl[3] = '{16'h07E0, 24'h00FF00};
        tbl[4] = '{16'h001F, 24'h0000FF};
        tbl[5] = '{16'h0000, 24'h000000};
        tbl[6] = '{16'h8410, 24'h848284};
        tbl[7] = '{16'hF81F, 24'hFF00FF};
        bar_tab[0] = 24'hFFFFFF; bar_tab[1] = 24'hFFFF00;
        bar_tab[2] = 24'h00FFFF; bar_tab[3] = 24'h00FF00;
        bar_tab[4] = 24'hFF00FF; bar_tab[5] = 24'hFF0000;
        bar_tab[6] = 24'h0000FF; bar_tab[7] = 24'h000000;
        plan[0] = 2'd0; plan[1] = 2'd0; plan[2] = 2'd1;
        plan[3] = 2'd0; plan[4] = 2'd2; plan[5] = 2'd3;
        for (int i = 6; i < NPLAN; i++) plan[i] = 2'($urandom_range(0, 3));
        for (int i = 0; i < NPLAN; i++) solid_plan[i] = 24'($urandom);

        rst_n     = 1'b0;
        mode      = 2'd0;
        solid_rgb = '0;
        data_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("in_reset");

        run(8 * FT + HT + 7, 8 * FT + HT + 7);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fmt565_%0d", i), 64'(cap[i]), 64'(tbl[i].exp));
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset("held_reset");

        run(2 * FT + 10, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
